applicant_score_collector: RTL and testbench
============================================

APPLICANT_SCORE_COLLECTOR -- requirements
Module: applicant_score_collector

Interface
REQ-001 The block SHALL have parameter PASS_MARK, default 100, the minimum total for a pass.
REQ-002 The block SHALL have parameter SCHOL_MARK, default 200, the minimum total for a scholarship.
REQ-003 The block SHALL have parameter NUM_SECT, default 4, the number of section grades per applicant.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 grade_valid  input  1  a section grade is offered.
REQ-008 grade_ready  output  1  the block can accept a section grade.
REQ-009 grade_data  input  8  unsigned section grade, 0..255.
REQ-010 abort  input  1  discards the applicant currently being collected.
REQ-011 res_valid  output  1  a result is presented.
REQ-012 res_ready  input  1  the downstream consumer accepts the result.
REQ-013 res_total  output  10  sum of the NUM_SECT grades.
REQ-014 res_failed / res_passed / res_scholarship  output  1 each  verdict flags.
REQ-015 res_id  output  8  applicant sequence number.

Function
REQ-016 The FSM SHALL have two states: COLLECT and REPORT.
REQ-017 In COLLECT, grade_ready SHALL be 1; in REPORT, grade_ready SHALL be 0.
REQ-018 A grade SHALL be accepted only on a cycle where grade_valid and grade_ready are both 1; each accepted grade adds zero-extended grade_data into a 10-bit accumulator and increments the section index.
REQ-019 The cycle after the NUM_SECT-th accepted grade, the FSM SHALL be in REPORT with res_valid=1, so result latency is 1 cycle.
REQ-020 In REPORT, res_total and all flags SHALL be registered values computed from the final sum.
REQ-021 Verdict rules:
- total < PASS_MARK: failed=1, passed=0, scholarship=0.
- PASS_MARK <= total < SCHOL_MARK: failed=0, passed=1, scholarship=0.
- total >= SCHOL_MARK: failed=0, passed=1, scholarship=1.
REQ-022 In REPORT, all res_* outputs SHALL be held stable until res_valid and res_ready are both 1.
REQ-023 On that handshake, the block SHALL:
- return to COLLECT on the next cycle;
- clear the accumulator and section index;
- increment res_id, wrapping 255 to 0;
- drive res_valid to 0.
REQ-024 res_valid SHALL never depend combinationally on res_ready, and grade_ready SHALL never depend combinationally on grade_valid.
REQ-025 An abort in COLLECT SHALL clear the accumulator and section index on the next edge, discard any grade offered in the same cycle, and leave res_id unchanged.
REQ-026 An abort in REPORT SHALL be ignored.
REQ-027 Outside REPORT, res_total and the flags SHALL read 0.

Reset
REQ-028 While rst_n=0, the block SHALL be in state COLLECT with grade_ready=1, res_valid=0, res_total=0, all flags 0, res_id=0, and the accumulator and index cleared.
REQ-029 A reset asserted mid-collection or mid-report SHALL discard the applicant immediately; no result is emitted.

Configuration
REQ-030 When APPLICANT_STATS_EN is defined, the block SHALL add the outputs stat_failed, stat_passed and stat_schol, each 16 bits.
REQ-031 With APPLICANT_STATS_EN defined, each stat counter SHALL:
- increment on every result handshake whose matching flag is 1;
- saturate at 65535;
- reset to 0.
REQ-032 When APPLICANT_STATS_EN is undefined, the stat ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 Package applicant_pkg SHALL hold:
- the FSM state typedef;
- SUM_W=10;
- the default PASS_MARK, SCHOL_MARK and NUM_SECT constants.
REQ-034 Sub-module grade_classifier SHALL be purely combinational: it maps a SUM_W-bit total to the three verdict flags.

Verification
REQ-035 Grades 25,25,24,25, then res_ready=1 -> res_valid=1 one cycle after the 4th grade; total=99, failed=1; res_id=0.
REQ-036 Grades 25,25,25,25 and then 50,50,50,50 -> total 100 gives passed=1, scholarship=0; total 200 gives scholarship=1, passed=1; res_id=1.
REQ-037 Grades 255 x4 with res_ready=0 for 5 cycles -> total=1020, outputs stable, grade_ready=0 throughout, handshake on cycle 6.
REQ-038 Two grades, then abort together with grade_valid, then 4 grades of 60 -> total=240; the aborted applicant produces no result.
REQ-039 rst_n pulsed low during REPORT -> res_valid=0 immediately, res_id=0; 256 results -> res_id wraps to 0.
REQ-040 With APPLICANT_STATS_EN: 3 fail, 2 pass, 1 scholarship results -> stat_failed=3, stat_passed=3, stat_schol=1.

Source files
------------

// File: rtl/applicant_pkg.sv
// Shared types and constants for the applicant score collector.
package applicant_pkg;
  typedef enum logic {COLLECT, REPORT} state_t;

  localparam int SUM_W          = 10;
  localparam int DEF_PASS_MARK  = 100;
  localparam int DEF_SCHOL_MARK = 200;
  localparam int DEF_NUM_SECT   = 4;
endpackage

// File: rtl/grade_classifier.sv
// Combinational verdict decode: maps an applicant total to fail/pass/scholarship flags.
module grade_classifier
  import applicant_pkg::*;
#(
  parameter int PASS_MARK  = DEF_PASS_MARK,
  parameter int SCHOL_MARK = DEF_SCHOL_MARK
) (
  input  logic [SUM_W-1:0] total,
  output logic             failed,
  output logic             passed,
  output logic             scholarship
);
  assign failed      = total < SUM_W'(PASS_MARK);
  assign passed      = !failed;
  assign scholarship = !failed && (total >= SUM_W'(SCHOL_MARK));
endmodule

// File: rtl/applicant_score_collector.sv
// Collects NUM_SECT section grades per applicant and reports total, verdict and id.
// Define APPLICANT_STATS_EN to add saturating per-verdict result counters.
module applicant_score_collector
  import applicant_pkg::*;
#(
  parameter int PASS_MARK  = DEF_PASS_MARK,
  parameter int SCHOL_MARK = DEF_SCHOL_MARK,
  parameter int NUM_SECT   = DEF_NUM_SECT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             grade_valid,
  output logic             grade_ready,
  input  logic [7:0]       grade_data,
  input  logic             abort,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SUM_W-1:0] res_total,
  output logic             res_failed,
  output logic             res_passed,
  output logic             res_scholarship,
  output logic [7:0]       res_id
`ifdef APPLICANT_STATS_EN
  ,
  output logic [15:0]      stat_failed,
  output logic [15:0]      stat_passed,
  output logic [15:0]      stat_schol
`endif
);
  localparam int IDX_W = $clog2(NUM_SECT + 1);

  state_t           state;
  logic [SUM_W-1:0] acc;
  logic [IDX_W-1:0] idx;

  logic [SUM_W-1:0] acc_next;
  logic             accept, last, hs;
  logic             c_failed, c_passed, c_schol;

  assign acc_next = acc + {{(SUM_W-8){1'b0}}, grade_data};
  assign accept   = (state == COLLECT) && grade_valid && !abort;
  assign last     = (idx == IDX_W'(NUM_SECT - 1));
  assign hs       = (state == REPORT) && res_ready;

  // Classify the sum including the grade arriving now, so REPORT outputs load in one edge.
  grade_classifier #(.PASS_MARK(PASS_MARK), .SCHOL_MARK(SCHOL_MARK)) u_cls (
    .total      (acc_next),
    .failed     (c_failed),
    .passed     (c_passed),
    .scholarship(c_schol)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= COLLECT;
      acc             <= '0;
      idx             <= '0;
      grade_ready     <= 1'b1;
      res_valid       <= 1'b0;
      res_total       <= '0;
      res_failed      <= 1'b0;
      res_passed      <= 1'b0;
      res_scholarship <= 1'b0;
      res_id          <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (abort) begin
            acc <= '0;
            idx <= '0;
          end else if (accept) begin
            if (last) begin
              state           <= REPORT;
              grade_ready     <= 1'b0;
              res_valid       <= 1'b1;
              res_total       <= acc_next;
              res_failed      <= c_failed;
              res_passed      <= c_passed;
              res_scholarship <= c_schol;
              acc             <= '0;
              idx             <= '0;
            end else begin
              acc <= acc_next;
              idx <= idx + 1'b1;
            end
          end
        end
        REPORT: begin
          if (hs) begin
            state           <= COLLECT;
            grade_ready     <= 1'b1;
            res_valid       <= 1'b0;
            res_total       <= '0;
            res_failed      <= 1'b0;
            res_passed      <= 1'b0;
            res_scholarship <= 1'b0;
            res_id          <= res_id + 8'd1;
            acc             <= '0;
            idx             <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

`ifdef APPLICANT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_failed <= '0;
      stat_passed <= '0;
      stat_schol  <= '0;
    end else if (hs) begin
      if (res_failed && stat_failed != 16'hFFFF)      stat_failed <= stat_failed + 16'd1;
      if (res_passed && stat_passed != 16'hFFFF)      stat_passed <= stat_passed + 16'd1;
      if (res_scholarship && stat_schol != 16'hFFFF)  stat_schol  <= stat_schol + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_applicant_score_collector.sv
// Directed self-checking bench for applicant_score_collector.
module tb_applicant_score_collector;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       grade_valid;
  logic       grade_ready;
  logic [7:0] grade_data;
  logic       abort;
  logic       res_valid;
  logic       res_ready;
  logic [9:0] res_total;
  logic       res_failed, res_passed, res_scholarship;
  logic [7:0] res_id;
`ifdef APPLICANT_STATS_EN
  logic [15:0] stat_failed, stat_passed, stat_schol;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  applicant_score_collector dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .grade_valid    (grade_valid),
    .grade_ready    (grade_ready),
    .grade_data     (grade_data),
    .abort          (abort),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_total      (res_total),
    .res_failed     (res_failed),
    .res_passed     (res_passed),
    .res_scholarship(res_scholarship),
    .res_id         (res_id)
`ifdef APPLICANT_STATS_EN
    ,
    .stat_failed    (stat_failed),
    .stat_passed    (stat_passed),
    .stat_schol     (stat_schol)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] g);
    grade_valid = 1'b1;
    grade_data  = g;
    tick();
    grade_valid = 1'b0;
  endtask

  task automatic send4(input logic [7:0] g0, g1, g2, g3);
    send(g0); send(g1); send(g2); send(g3);
  endtask

  task automatic take();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  // Checks the presented result: total, failed, passed, scholarship, id.
  task automatic chk_res(input string tag, input int tot, input logic f, p, s, input int id);
    chk({tag, ".valid"}, res_valid, 1);
    chk({tag, ".gready"}, grade_ready, 0);
    chk({tag, ".total"}, res_total, tot);
    chk({tag, ".failed"}, res_failed, f);
    chk({tag, ".passed"}, res_passed, p);
    chk({tag, ".schol"}, res_scholarship, s);
    chk({tag, ".id"}, res_id, id);
  endtask

  initial begin
    rst_n = 1'b0; grade_valid = 1'b0; grade_data = 8'd0; abort = 1'b0; res_ready = 1'b0;
    #12;
    chk("rst.gready", grade_ready, 1);
    chk("rst.valid", res_valid, 0);
    chk("rst.total", res_total, 0);
    chk("rst.flags", {res_failed, res_passed, res_scholarship}, 0);
    chk("rst.id", res_id, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Failing applicant, one-cycle latency
    send(25); send(25); send(24);
    chk("t1.notyet", res_valid, 0);
    send(25);
    chk_res("t1", 99, 1, 0, 0, 0);
    take();
    chk("t1.post.valid", res_valid, 0);
    chk("t1.post.total", res_total, 0);
    chk("t1.post.gready", grade_ready, 1);
    chk("t1.post.id", res_id, 1);

    // Pass boundary and scholarship boundary
    send4(25, 25, 25, 25);
    chk_res("t2a", 100, 0, 1, 0, 1);
    take();
    send4(50, 50, 50, 50);
    chk_res("t2b", 200, 0, 1, 1, 2);
    take();

    // Backpressure: hold 5 cycles, grades offered and abort are ignored
    send4(255, 255, 255, 255);
    for (int i = 0; i < 5; i++) begin
      grade_valid = 1'b1; grade_data = 8'd7; abort = (i == 2);
      tick();
      chk_res($sformatf("t3.hold%0d", i), 1020, 0, 1, 1, 3);
    end
    grade_valid = 1'b0; abort = 1'b0;
    take();
    chk("t3.post.valid", res_valid, 0);
    chk("t3.post.id", res_id, 4);

    // Abort mid-collection discards partial sum and the concurrent grade
    send(10); send(20);
    abort = 1'b1; grade_valid = 1'b1; grade_data = 8'd99;
    tick();
    abort = 1'b0; grade_valid = 1'b0;
    chk("t4.abort.valid", res_valid, 0);
    send(60); send(60);
    chk("t4.two.valid", res_valid, 0);
    send(60);
    chk("t4.three.valid", res_valid, 0);
    send(60);
    chk_res("t4", 240, 0, 1, 1, 4);
    take();

    // Reset during REPORT
    send4(1, 2, 3, 4);
    chk("t5.pre.valid", res_valid, 1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("t5.rst.valid", res_valid, 0);
    chk("t5.rst.id", res_id, 0);
    chk("t5.rst.total", res_total, 0);
    chk("t5.rst.gready", grade_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // 3 fail, 2 pass, 1 scholarship
    for (int i = 0; i < 3; i++) begin send4(0, 0, 0, 0); take(); end
    for (int i = 0; i < 2; i++) begin send4(30, 30, 30, 30); take(); end
    send4(60, 60, 60, 60);
    chk_res("t6.schol", 240, 0, 1, 1, 5);
    take();
`ifdef APPLICANT_STATS_EN
    chk("t6.stat_failed", stat_failed, 3);
    chk("t6.stat_passed", stat_passed, 3);
    chk("t6.stat_schol", stat_schol, 1);
`endif
    chk("t6.id", res_id, 6);

    // id wrap: 256 results since reset brings it back to 0
    for (int i = 0; i < 249; i++) begin send4(0, 0, 0, 0); take(); end
    chk("t7.id255", res_id, 255);
    send4(0, 0, 0, 0);
    chk_res("t7.last", 0, 1, 0, 0, 255);
    take();
    chk("t7.wrap", res_id, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
